// File: rtl/alu_shift_pipe.sv
// Two-stage shift/rotate pipeline with valid/ready handshake on both sides.
// Optional {carry, zero, negative} flags when ALU_SHIFT_FLAGS_EN is defined.
module alu_shift_pipe #(
    parameter int WIDTH = 16,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [AMT_W-1:0] shift_amount,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_SHIFT_FLAGS_EN
    output logic [WIDTH-1:0] dout,
    output logic [2:0]       flags
);
`else
    output logic [WIDTH-1:0] dout
);
`endif

    localparam int HALF = AMT_W / 2;
    localparam logic [AMT_W-1:0] LO_MASK = AMT_W'((1 << HALF) - 1);

    localparam logic [2:0] MODE_ROR = 3'b000;
    localparam logic [2:0] MODE_ROL = 3'b001;
    localparam logic [2:0] MODE_LSL = 3'b010;
    localparam logic [2:0] MODE_LSR = 3'b011;
    localparam logic [2:0] MODE_ASR = 3'b100;

    // Rotates use a doubled word so a zero amount needs no special case.
    function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] x,
                                                  input logic [2:0]       m,
                                                  input logic [AMT_W-1:0] n);
        logic [2*WIDTH-1:0] rot;
        logic [WIDTH-1:0]   res;
        res = x;
        rot = '0;
        case (m)
            MODE_ROR: begin
                rot = {x, x} >> n;
                res = rot[WIDTH-1:0];
            end
            MODE_ROL: begin
                rot = {x, x} << n;
                res = rot[2*WIDTH-1:WIDTH];
            end
            MODE_LSL: res = x << n;
            MODE_LSR: res = x >> n;
            MODE_ASR: res = $signed(x) >>> n;
            default:  res = x;
        endcase
        return res;
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [2:0]       s1_mode;
    logic [AMT_W-1:0] s1_amt_lo;
    logic             s2_valid;
    logic             s2_adv;
    logic [AMT_W-1:0] amt_hi;
    logic [WIDTH-1:0] s1_result;
    logic [WIDTH-1:0] s2_result;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;
    assign amt_hi    = shift_amount & ~LO_MASK;
    assign s1_result = shift_op(operand1, mode, amt_hi);
    assign s2_result = shift_op(s1_data, s1_mode, s1_amt_lo);

`ifdef ALU_SHIFT_FLAGS_EN
    // Last bit shifted out by a single shift stage; 0 for rotates and pass-through.
    function automatic logic shift_carry(input logic [WIDTH-1:0] x,
                                         input logic [2:0]       m,
                                         input logic [AMT_W-1:0] n);
        logic [WIDTH-1:0] t;
        logic             c;
        t = '0;
        c = 1'b0;
        if (n != '0) begin
            case (m)
                MODE_LSL: begin
                    t = x >> (WIDTH - int'(n));
                    c = t[0];
                end
                MODE_LSR, MODE_ASR: begin
                    t = x >> (int'(n) - 1);
                    c = t[0];
                end
                default: c = 1'b0;
            endcase
        end
        return c;
    endfunction

    logic s1_carry;
    logic s1_amt_nz;
    logic s1_carry_next;
    logic s2_carry;

    assign s1_carry_next = shift_carry(operand1, mode, amt_hi);

    // The final carry comes from stage 2 only if stage 2 actually shifted.
    always_comb begin
        s2_carry = 1'b0;
        case (s1_mode)
            MODE_ROR: s2_carry = s1_amt_nz & s2_result[WIDTH-1];
            MODE_ROL: s2_carry = s1_amt_nz & s2_result[0];
            MODE_LSL, MODE_LSR, MODE_ASR:
                s2_carry = (s1_amt_lo != '0) ? shift_carry(s1_data, s1_mode, s1_amt_lo)
                                             : s1_carry;
            default:  s2_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_carry  <= 1'b0;
            s1_amt_nz <= 1'b0;
            flags     <= '0;
        end else begin
            if (s2_adv && s1_valid) begin
                flags <= {s2_carry, (s2_result == '0), s2_result[WIDTH-1]};
            end
            if (in_ready && in_valid) begin
                s1_carry  <= s1_carry_next;
                s1_amt_nz <= (shift_amount != '0);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= '0;
            s1_amt_lo <= '0;
            dout      <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    dout <= s2_result;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data   <= s1_result;
                    s1_mode   <= mode;
                    s1_amt_lo <= shift_amount & LO_MASK;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Bench for alu_shift_pipe (WIDTH=16): vector table, directed stall/reset/latency
// sequences and a random stream, all checked through an expected-result queue.
module tb_alu_shift_pipe;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  f;
    } exp_t;

    typedef struct {
        logic [2:0]  m;
        logic [3:0]  n;
        logic [15:0] x;
        logic [15:0] d;
        logic [2:0]  f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] operand1 = '0;
    logic [3:0]  shift_amount = '0;
    logic [2:0]  mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] dout;
`ifdef ALU_SHIFT_FLAGS_EN
    logic [2:0]  flags;
`endif

    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];
    vec_t vecs[$];

    alu_shift_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .shift_amount(shift_amount), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef ALU_SHIFT_FLAGS_EN
        .dout(dout), .flags(flags)
`else
        .dout(dout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Bit-by-bit reference, written independently of the shifter structure.
    function automatic exp_t model(input logic [15:0] x, input logic [2:0] m, input int n);
        exp_t e;
        logic [15:0] r;
        logic c;
        r = x;
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            case (m)
                3'd0: r[i] = x[(i + n) % 16];
                3'd1: r[i] = x[(i - n + 16) % 16];
                3'd2: r[i] = (i >= n) ? x[i - n] : 1'b0;
                3'd3: r[i] = (i + n < 16) ? x[i + n] : 1'b0;
                3'd4: r[i] = (i + n < 16) ? x[i + n] : x[15];
                default: r[i] = x[i];
            endcase
        end
        if (n != 0) begin
            case (m)
                3'd0: c = r[15];
                3'd1: c = r[0];
                3'd2: c = x[16 - n];
                3'd3, 3'd4: c = x[n - 1];
                default: c = 1'b0;
            endcase
        end
        e.d = r;
        e.f = {c, (r == 16'h0), r[15]};
        return e;
    endfunction

    // Output monitor: pops on every output transfer, checks hold while stalled.
    bit          held = 1'b0;
    logic [15:0] held_dout;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) chk("stall_hold", {15'd0, out_valid, dout}, {15'd0, 1'b1, held_dout});
            if (out_valid && out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("dout", 32'(dout), 32'(e.d));
`ifdef ALU_SHIFT_FLAGS_EN
                    chk("flags", 32'(flags), 32'(e.f));
`endif
                end
            end else if (out_valid) begin
                held = 1'b1;
                held_dout = dout;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic offer(input logic [15:0] x, input logic [2:0] m, input logic [3:0] n,
                         input exp_t e, output bit acc);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        operand1 = x;
        mode = m;
        shift_amount = n;
        #1;
        acc = in_ready;
        if (acc) sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] x, input logic [2:0] m, input logic [3:0] n,
                        input exp_t e);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc) begin
            offer(x, m, n, e, acc);
            tries++;
            if (!acc && tries > 100) begin
                chk("send_timeout", 32'(tries), 32'd0);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
        operand1 = 16'($urandom);
        mode = 3'($urandom);
        shift_amount = 4'($urandom);
    endtask

    task automatic drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 300) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Pipeline must be empty and out_ready high on entry.
    task automatic lat_test(input logic [15:0] x, input logic [2:0] m, input logic [3:0] n,
                            input exp_t e);
        send(x, m, n, e);
        #1;
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        chk("lat_cycle2_dout", 32'(dout), 32'(e.d));
        @(negedge clk);
    endtask

    initial begin
        bit   acc;
        exp_t e;
        logic [15:0] x;
        logic [2:0]  m;
        logic [3:0]  n;

        vecs.push_back('{3'd1, 4'd1,  16'h8001, 16'h0003, 3'b100});
        vecs.push_back('{3'd4, 4'd15, 16'h8000, 16'hFFFF, 3'b001});
        vecs.push_back('{3'd3, 4'd15, 16'h8000, 16'h0001, 3'b000});
        vecs.push_back('{3'd2, 4'd1,  16'h8000, 16'h0000, 3'b110});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{3'(i), 4'd0, 16'hA5A5, 16'hA5A5, 3'b001});
        vecs.push_back('{3'd7, 4'd5,  16'h1234, 16'h1234, 3'b000});
        vecs.push_back('{3'd5, 4'd7,  16'hFFFF, 16'hFFFF, 3'b001});
        vecs.push_back('{3'd2, 4'd4,  16'h00F1, 16'h0F10, 3'b000});
        vecs.push_back('{3'd3, 4'd4,  16'h00F1, 16'h000F, 3'b000});
        vecs.push_back('{3'd0, 4'd1,  16'h0001, 16'h8000, 3'b101});
        vecs.push_back('{3'd4, 4'd3,  16'h4000, 16'h0800, 3'b000});
        vecs.push_back('{3'd2, 4'd15, 16'h0003, 16'h8000, 3'b101});

        // Reset state, with a request offered during reset.
        in_valid = 1'b1;
        operand1 = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
`ifdef ALU_SHIFT_FLAGS_EN
        chk("reset_flags", 32'(flags), 32'd0);
`endif
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("post_reset_no_output", 32'(out_valid), 32'd0);
        @(negedge clk);

        lat_test(16'h1234, 3'd0, 4'd4, '{16'h4123, 3'b000});

        foreach (vecs[i]) send(vecs[i].x, vecs[i].m, vecs[i].n, '{vecs[i].d, vecs[i].f});
        drain();

        // Stall: two requests fit, the third is refused until out_ready rises.
        out_ready = 1'b0;
        offer(16'h0F0F, 3'd0, 4'd8, model(16'h0F0F, 3'd0, 8), acc);
        chk("stall_acc1", 32'(acc), 32'd1);
        offer(16'h1357, 3'd2, 4'd3, model(16'h1357, 3'd2, 3), acc);
        chk("stall_acc2", 32'(acc), 32'd1);
        for (int k = 0; k < 3; k++) begin
            offer(16'h9ABC, 3'd4, 4'd6, model(16'h9ABC, 3'd4, 6), acc);
            chk("stall_acc3_refused", 32'(acc), 32'd0);
        end
        out_ready = 1'b1;
        send(16'h9ABC, 3'd4, 4'd6, model(16'h9ABC, 3'd4, 6));
        drain();

        // Reset with two requests in flight.
        out_ready = 1'b0;
        send(16'h1111, 3'd1, 4'd2, model(16'h1111, 3'd1, 2));
        send(16'h2222, 3'd3, 4'd1, model(16'h2222, 3'd3, 1));
        rst = 1'b1;
        in_valid = 1'b1;
        operand1 = 16'h7777;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        lat_test(16'h0003, 3'd2, 4'd15, '{16'h8000, 3'b101});

        // Random stream under random back-pressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            x = 16'($urandom);
            m = 3'($urandom);
            n = 4'($urandom);
            send(x, m, n, model(x, m, int'(n)));
        end
        rand_ready = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_shift_pipe.md
ALU_SHIFT_PIPE -- requirements
Module: alu_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be a power of two, at least 4.
REQ-002 Derived AMT_W = log2(WIDTH): shift-amount width, 4 at default.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present this cycle.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 operand1  input  WIDTH  value to shift or rotate.
REQ-008 shift_amount  input  AMT_W  shift distance, 0..WIDTH-1.
REQ-009 mode  input  3  000 ROR, 001 ROL, 010 LSL, 011 LSR, 100 ASR, 101-111 pass-through.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 dout  output  WIDTH  result.
REQ-013 flags  output  3  {carry, zero, negative}; present only when the configuration macro is defined.

Function
REQ-014 Transfers SHALL occur when in_valid and in_ready are both high (input side), and when out_valid and out_ready are both high (output side).
REQ-015 The block SHALL be a 2-stage pipeline. Stage 1 registers the request with the shift applied for amount bits [AMT_W-1:AMT_W/2]; stage 2 applies bits [AMT_W/2-1:0].
REQ-016 Latency SHALL be 2 cycles from input transfer to out_valid high when out_ready is held high; throughput SHALL be 1 result per cycle.
REQ-017 A stage SHALL advance when its successor is empty or draining in the same cycle. in_ready = !s1_valid || s2 advance; out_valid = s2_valid.
REQ-018 While out_valid is high and out_ready is low, dout and flags SHALL hold stable. At most 2 requests SHALL be buffered, with no loss or reordering.
REQ-019 ROR and ROL SHALL rotate modulo WIDTH.
REQ-020 LSL and LSR SHALL fill vacated bits with 0.
REQ-021 ASR SHALL fill vacated bits with operand1[WIDTH-1].
REQ-022 Pass-through modes SHALL produce dout = operand1.
REQ-023 shift_amount = 0 SHALL produce dout = operand1 in every mode.
REQ-024 When an input transfer and an output transfer occur in the same cycle with both stages full, both SHALL complete with no bubble.
REQ-025 mode and shift_amount SHALL be captured at the input transfer; input changes while in_ready is low SHALL have no effect.

Reset
REQ-026 While rst is high at a clock edge, s1_valid and s2_valid SHALL clear, out_valid SHALL be 0, dout SHALL be 0, and flags SHALL be 0.
REQ-027 Reset SHALL discard in-flight requests; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 Requests presented while rst is high SHALL be ignored.

Configuration
REQ-029 Macro ALU_SHIFT_FLAGS_EN defined: the flags port and flag logic SHALL be present.
- carry: for LSL/LSR/ASR, the last bit shifted out; for ROR, dout[WIDTH-1]; for ROL, dout[0]; 0 when the amount is 0 or the mode is pass-through.
- zero: dout == 0.
- negative: dout[WIDTH-1].
- Flags SHALL be pipelined alongside dout.
REQ-030 Macro undefined: there SHALL be no flags port and no flag logic, and all other behaviour SHALL be identical.

Verification (WIDTH=16)
REQ-031 ROR 0x1234 by 4 -> dout 0x4123 exactly 2 cycles later; with flags, carry 0, zero 0, negative 0.
REQ-032 ROL 0x8001 by 1 -> 0x0003. ASR 0x8000 by 15 -> 0xFFFF, negative 1. LSR 0x8000 by 15 -> 0x0001, carry 0.
REQ-033 LSL 0x8000 by 1 -> 0x0000, zero 1, carry 1. Any mode with amount 0 on 0xA5A5 -> 0xA5A5, carry 0. Mode 111 on 0x1234 -> 0x1234.
REQ-034 Hold out_ready low and offer 3 back-to-back requests -> 2 accepted and in_ready low. Raise out_ready -> all 3 results in order, with dout stable while stalled.
REQ-035 Assert rst one cycle after accepting 2 requests -> out_valid 0, dout 0, no stale result after release. A new request then yields its result after 2 cycles.
REQ-036 Random streams of mode, amount and operand under random out_ready -> results match a reference model in order, with no drops or duplicates.
